// File: rtl/scan_loader_pkg.sv
// Shared encodings for the scan chain loader: command opcodes,
// controller states and transfer modes.
package scan_loader_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_DUMP = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_PUSH,
        ST_RUN
    } state_t;

    typedef enum logic {
        MODE_LOAD,
        MODE_DUMP
    } mode_t;

endpackage

// File: rtl/scan_byte_serdes.sv
// Byte serialiser/deserialiser for the processor scan chain.
// Sends shift_byte LSB first and captures scan_out into the same bit slot.
module scan_byte_serdes (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       shift,
    input  logic       recirc,
    input  logic       scan_out,
    output logic       scan_in,
    output logic [7:0] capture,
    output logic       last_bit
);

    logic [7:0] r_shift_byte;
    logic [7:0] r_capture;
    logic [2:0] r_bit_cnt;

    // Latch the parallel byte and step through its bits while shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_byte <= '0;
            r_capture    <= '0;
            r_bit_cnt    <= '0;
        end else begin
            if (load) begin
                r_shift_byte <= din;
            end
            if (shift) begin
                r_capture[r_bit_cnt] <= scan_out;
                r_bit_cnt            <= r_bit_cnt + 3'd1;
            end
        end
    end

    // Recirculation feeds the chain back into itself so a dump is non-destructive.
    assign scan_in  = recirc ? scan_out : r_shift_byte[r_bit_cnt];
    assign capture  = r_capture;
    assign last_bit = (r_bit_cnt == 3'd7);

endmodule

// File: rtl/scan_chain_loader.sv
// Host-side scan chain controller: byte-wide load/dump of the processor
// scan chain and gated run control with a saturating cycle counter.
module scan_chain_loader
    import scan_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 512,
    parameter int RUNCNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd_op,
    output logic                cmd_ready,
    input  logic                din_valid,
    input  logic [7:0]          din,
    output logic                din_ready,
    output logic                dout_valid,
    output logic [7:0]          dout,
    input  logic                dout_ready,
    output logic                scan_enable,
    output logic                scan_in,
    input  logic                scan_out,
    output logic                proc_en,
    input  logic                halt,
    output logic                busy,
    output logic                done,
    output logic [RUNCNT_W-1:0] run_cycles
);

    localparam int NBYTES = CHAIN_LEN / 8;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

    state_t              r_state;
    mode_t               r_mode;
    logic [BYTE_W-1:0]   r_byte_cnt;
    logic                r_cmd_ready;
    logic                r_din_ready;
    logic                r_dout_valid;
    logic                r_scan_enable;
    logic                r_proc_en;
    logic                r_busy;
    logic                r_done;
    logic [RUNCNT_W-1:0] r_run_cycles;

    logic       w_cmd_fire;
    logic       w_din_fire;
    logic       w_dout_fire;
    logic       w_ser_in;
    logic       w_last_bit;
    logic [7:0] w_capture;

    assign w_cmd_fire  = cmd_valid & r_cmd_ready;
    assign w_din_fire  = din_valid & r_din_ready;
    assign w_dout_fire = r_dout_valid & dout_ready;

    scan_byte_serdes u_serdes (
        .clk      (clk),
        .rst      (rst),
        .load     (w_din_fire),
        .din      (din),
        .shift    (r_scan_enable),
        .recirc   (r_mode == MODE_DUMP),
        .scan_out (scan_out),
        .scan_in  (w_ser_in),
        .capture  (w_capture),
        .last_bit (w_last_bit)
    );

    // Control FSM; every output flag is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_LOAD;
            r_byte_cnt    <= '0;
            r_cmd_ready   <= 1'b1;
            r_din_ready   <= 1'b0;
            r_dout_valid  <= 1'b0;
            r_scan_enable <= 1'b0;
            r_proc_en     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_run_cycles  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        unique case (cmd_op)
                            OP_LOAD: begin
                                r_state     <= ST_FETCH;
                                r_mode      <= MODE_LOAD;
                                r_byte_cnt  <= '0;
                                r_cmd_ready <= 1'b0;
                                r_din_ready <= 1'b1;
                                r_busy      <= 1'b1;
                            end
                            OP_DUMP: begin
                                r_state       <= ST_SHIFT;
                                r_mode        <= MODE_DUMP;
                                r_byte_cnt    <= '0;
                                r_cmd_ready   <= 1'b0;
                                r_scan_enable <= 1'b1;
                                r_busy        <= 1'b1;
                            end
                            OP_RUN: begin
                                r_state      <= ST_RUN;
                                r_run_cycles <= '0;
                                r_proc_en    <= 1'b1;
                                r_busy       <= 1'b1;
                            end
                            default: begin
                                r_done <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_FETCH: begin
                    if (w_din_fire) begin
                        r_state       <= ST_SHIFT;
                        r_din_ready   <= 1'b0;
                        r_scan_enable <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_last_bit) begin
                        r_state       <= ST_PUSH;
                        r_scan_enable <= 1'b0;
                        r_dout_valid  <= 1'b1;
                    end
                end
                ST_PUSH: begin
                    if (w_dout_fire) begin
                        r_dout_valid <= 1'b0;
                        r_byte_cnt   <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_state     <= ST_IDLE;
                            r_done      <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else if (r_mode == MODE_LOAD) begin
                            r_state     <= ST_FETCH;
                            r_din_ready <= 1'b1;
                        end else begin
                            r_state       <= ST_SHIFT;
                            r_scan_enable <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_proc_en && (r_run_cycles != '1)) begin
                        r_run_cycles <= r_run_cycles + 1'b1;
                    end
                    if (halt || w_cmd_fire) begin
                        r_state   <= ST_IDLE;
                        r_proc_en <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign din_ready   = r_din_ready;
    assign dout_valid  = r_dout_valid;
    assign dout        = w_capture;
    assign scan_enable = r_scan_enable;
    assign scan_in     = r_scan_enable & w_ser_in;
    assign proc_en     = r_proc_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign run_cycles  = r_run_cycles;

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader on a 16-flop behavioural chain,
// plus a 4-bit run counter instance for saturation.
module tb_scan_chain_loader;
    import scan_loader_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       din_valid;
    logic [7:0] din;
    logic       din_ready;
    logic       dout_valid;
    logic [7:0] dout;
    logic       dout_ready;
    logic       scan_enable;
    logic       scan_in;
    logic       scan_out;
    logic       proc_en;
    logic       halt;
    logic       busy;
    logic       done;
    logic [15:0] run_cycles;

    logic       cmd_valid2;
    logic [1:0] cmd_op2;
    logic       cmd_ready2;
    logic       din_ready2;
    logic       dout_valid2;
    logic [7:0] dout2;
    logic       scan_enable2;
    logic       scan_in2;
    logic       proc_en2;
    logic       busy2;
    logic       done2;
    logic [3:0] run_cycles2;

    logic [15:0] chain;
    int total = 0;
    int bad = 0;
    int se_cnt = 0;
    int pe_cnt = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    int stall_bad = 0;

    scan_chain_loader #(.CHAIN_LEN(16), .RUNCNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .din_valid(din_valid), .din(din), .din_ready(din_ready),
        .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
        .proc_en(proc_en), .halt(halt), .busy(busy), .done(done),
        .run_cycles(run_cycles)
    );

    scan_chain_loader #(.CHAIN_LEN(16), .RUNCNT_W(4)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid2), .cmd_op(cmd_op2), .cmd_ready(cmd_ready2),
        .din_valid(1'b0), .din(8'h00), .din_ready(din_ready2),
        .dout_valid(dout_valid2), .dout(dout2), .dout_ready(1'b1),
        .scan_enable(scan_enable2), .scan_in(scan_in2), .scan_out(1'b0),
        .proc_en(proc_en2), .halt(1'b0), .busy(busy2), .done(done2),
        .run_cycles(run_cycles2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: scan_in enters at bit 15, bit 0 is the tail.
    assign scan_out = chain[0];
    initial chain = '0;
    always @(posedge clk) begin
        if (scan_enable) chain <= {scan_in, chain[15:1]};
    end

    always @(posedge clk) begin
        if (scan_enable) se_cnt <= se_cnt + 1;
        if (proc_en) pe_cnt <= pe_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (scan_enable && proc_en) both_cnt <= both_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op);
        cmd_op = op;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] b, input int dly);
        if (scan_enable) stall_bad++;
        repeat (dly) begin
            @(negedge clk);
            if (scan_enable) stall_bad++;
        end
        chk("din_ready", din_ready, 1'b1);
        din = b;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic take_byte(output logic [7:0] b, input int pdly);
        int n = 0;
        while (!dout_valid && n < 32) begin
            @(negedge clk);
            n++;
        end
        chk("dout_valid_wait", dout_valid, 1'b1);
        b = dout;
        repeat (pdly) begin
            @(negedge clk);
            if (scan_enable || dout !== b || !dout_valid) stall_bad++;
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    task automatic xfer(input logic [1:0] op, input logic [15:0] dw,
                        input int dly, input int pdly,
                        output logic [15:0] ow);
        logic [7:0] b;
        send_cmd(op);
        chk("busy_xfer", busy, 1'b1);
        chk("cmd_ready_xfer", cmd_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (op == OP_LOAD) feed_byte(dw[8*i +: 8], dly);
            take_byte(b, pdly);
            ow[8*i +: 8] = b;
        end
        chk("done_xfer", done, 1'b1);
        @(negedge clk);
        chk("done_low_xfer", done, 1'b0);
    endtask

    initial begin
        logic [15:0] ow;
        int se0, dc0, pe0, bc0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = OP_STOP;
        din_valid = 1'b0;
        din = 8'h00;
        dout_ready = 1'b0;
        halt = 1'b0;
        cmd_valid2 = 1'b0;
        cmd_op2 = OP_STOP;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_outs", {scan_enable, scan_in, proc_en, din_ready,
                         dout_valid, busy, done}, 7'd0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_run_cycles", run_cycles, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // LOAD A5,3C into a zeroed chain, then DUMP it back.
        se0 = se_cnt;
        dc0 = done_cnt;
        xfer(OP_LOAD, 16'h3CA5, 0, 0, ow);
        chk("load1_dout", ow, 16'h0000);
        chk("load1_se_cycles", se_cnt - se0, 16);
        chk("load1_done_cnt", done_cnt - dc0, 1);
        chk("load1_chain", chain, 16'h3CA5);
        chk("idle_after_load", {busy, cmd_ready}, 2'b01);
        se0 = se_cnt;
        xfer(OP_DUMP, 16'h0000, 0, 0, ow);
        chk("dump1_dout", ow, 16'h3CA5);
        chk("dump1_chain", chain, 16'h3CA5);
        chk("dump1_se_cycles", se_cnt - se0, 16);

        // LOAD new data, then stalled LOAD of the same data.
        xfer(OP_LOAD, 16'hC35A, 0, 0, ow);
        chk("load2_dout", ow, 16'h3CA5);
        chk("load2_chain", chain, 16'hC35A);
        stall_bad = 0;
        xfer(OP_LOAD, 16'hC35A, 5, 7, ow);
        chk("stall_dout", ow, 16'hC35A);
        chk("stall_chain", chain, 16'hC35A);
        chk("stall_violations", stall_bad, 0);

        // RUN with halt arriving in the tenth enabled cycle.
        se0 = se_cnt;
        pe0 = pe_cnt;
        dc0 = done_cnt;
        bc0 = both_cnt;
        send_cmd(OP_RUN);
        chk("run_proc_en", proc_en, 1'b1);
        chk("run_cmd_ready", cmd_ready, 1'b1);
        repeat (9) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("halt_proc_en", proc_en, 1'b0);
        chk("halt_run_cycles", run_cycles, 16'd10);
        chk("halt_done", done, 1'b1);
        @(negedge clk);
        chk("halt_pe_cycles", pe_cnt - pe0, 10);
        chk("halt_done_cnt", done_cnt - dc0, 1);
        chk("run_no_scan", se_cnt - se0, 0);

        // RUN with halt already high at entry.
        pe0 = pe_cnt;
        halt = 1'b1;
        send_cmd(OP_RUN);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("halt0_proc_en", proc_en, 1'b0);
        chk("halt0_run_cycles", run_cycles, 16'd1);
        @(negedge clk);
        chk("halt0_pe_cycles", pe_cnt - pe0, 1);

        // RUN ended by STOP in the third cycle.
        send_cmd(OP_RUN);
        chk("stop_run_cleared", run_cycles, 16'd0);
        repeat (2) @(negedge clk);
        chk("stop_cmd_ready", cmd_ready, 1'b1);
        send_cmd(OP_STOP);
        chk("stop_proc_en", proc_en, 1'b0);
        chk("stop_run_cycles", run_cycles, 16'd3);
        chk("stop_done", done, 1'b1);

        // RUN ended by a LOAD that must be discarded.
        @(negedge clk);
        send_cmd(OP_RUN);
        @(negedge clk);
        send_cmd(OP_LOAD);
        @(negedge clk);
        chk("discard_state", {busy, din_ready, proc_en, cmd_ready}, 4'b0001);
        chk("both_high", both_cnt - bc0, 0);

        // Reset during bit 4 of the second byte of a LOAD.
        send_cmd(OP_LOAD);
        feed_byte(8'h11, 0);
        take_byte(ow[7:0], 0);
        feed_byte(8'h22, 0);
        repeat (4) @(negedge clk);
        chk("pre_rst_shifting", scan_enable, 1'b1);
        dc0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {scan_enable, proc_en, busy, done,
                             din_ready, dout_valid}, 6'd0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_idle", {busy, cmd_ready, scan_enable}, 3'b010);
        @(negedge clk);
        chk("post_rst_done_cnt", done_cnt - dc0, 0);

        // 4-bit run counter saturates; STOP in IDLE only pulses done.
        cmd_op2 = OP_RUN;
        cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        repeat (19) @(negedge clk);
        chk("sat_proc_en_on", proc_en2, 1'b1);
        cmd_op2 = OP_STOP;
        cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        chk("sat_run_cycles", run_cycles2, 4'd15);
        chk("sat_proc_en_off", proc_en2, 1'b0);
        @(negedge clk);
        chk("sat_done_low", done2, 1'b0);
        cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        chk("idle_stop_done", done2, 1'b1);
        chk("idle_stop_outs", {run_cycles2, proc_en2, busy2, cmd_ready2,
                               scan_enable2, din_ready2, dout_valid2},
            {4'd15, 6'b001000});
        @(negedge clk);
        chk("idle_stop_done_low", done2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
